// File: rtl/pipe_scoreboard_hazard_unit.sv
// Scoreboard-based hazard unit and fetch/data memory-port arbiter for the shared-memory MIPS pipeline.
// Optional stall statistics counter enabled by defining HAZARD_STATS_EN.
module pipe_scoreboard_hazard_unit #(
  parameter int REG_COUNT   = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int LOAD_LAT    = 1,
  parameter int ALU_LAT     = 0,
  parameter int EARLY_EXTRA = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  waitrequest,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rs,
  input  logic [REG_ADDR_W-1:0] issue_rt,
  input  logic                  issue_rs_used,
  input  logic                  issue_rt_used,
  input  logic                  issue_rs_early,
  input  logic                  issue_rt_early,
  input  logic [REG_ADDR_W-1:0] issue_dest,
  input  logic                  issue_dest_we,
  input  logic                  issue_is_load,
  input  logic                  mem_req,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  id_ex_bubble,
  output logic                  fetch_mem_sel,
  output logic                  if_id_valid,
  output logic                  hazard_stall,
  output logic [31:0]           stall_cycles
);

  localparam int LOAD_TOT = LOAD_LAT + EARLY_EXTRA;
  localparam int ALU_TOT  = ALU_LAT + EARLY_EXTRA;
  localparam int MAX_TOT  = (LOAD_TOT > ALU_TOT) ? LOAD_TOT : ALU_TOT;
  localparam int CNT_W    = (MAX_TOT < 1) ? 1 : $clog2(MAX_TOT + 1);

  localparam logic [CNT_W-1:0] LOAD_TOT_C = CNT_W'(LOAD_TOT);
  localparam logic [CNT_W-1:0] ALU_TOT_C  = CNT_W'(ALU_TOT);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    DATA    = 2'd1,
    REFETCH = 2'd2
  } mem_state_t;

  mem_state_t       state;
  logic             prev_fetch;
  logic             freeze;
  logic             issue_fire;
  logic [CNT_W-1:0] cnt [1:REG_COUNT-1];
  logic [CNT_W-1:0] rs_cnt;
  logic [CNT_W-1:0] rt_cnt;
  logic             rs_hazard;
  logic             rt_hazard;

  // An ID-stage operand needs the value a full EARLY_EXTRA earlier than an EX-stage one.
  function automatic logic operand_hazard(input logic                  used,
                                          input logic                  early,
                                          input logic [REG_ADDR_W-1:0] addr,
                                          input logic [CNT_W-1:0]      c);
    logic hz;
    hz = 1'b0;
    if (used && (addr != '0)) begin
      if (early) hz = (c != '0);
      else       hz = (int'(c) > EARLY_EXTRA);
    end
    return hz;
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign freeze = waitrequest;

  always_comb begin
    rs_cnt = '0;
    rt_cnt = '0;
    for (int r = 1; r < REG_COUNT; r++) begin
      if (issue_rs == REG_ADDR_W'(r)) rs_cnt = cnt[r];
      if (issue_rt == REG_ADDR_W'(r)) rt_cnt = cnt[r];
    end
  end

  assign rs_hazard    = operand_hazard(issue_rs_used, issue_rs_early, issue_rs, rs_cnt);
  assign rt_hazard    = operand_hazard(issue_rt_used, issue_rt_early, issue_rt, rt_cnt);
  assign hazard_stall = issue_valid & (rs_hazard | rt_hazard);

  assign issue_fire = issue_valid & issue_dest_we & (issue_dest != '0) & ~hazard_stall &
                      (state == FETCH) & ~freeze;

  assign pc_write      = ~freeze & ~hazard_stall & (state == FETCH) & ~mem_req;
  assign if_id_write   = pc_write;
  assign id_ex_bubble  = hazard_stall & ~freeze;
  assign fetch_mem_sel = (state != DATA);
  assign if_id_valid   = (state == FETCH) & ~freeze & prev_fetch;

  // Newest producer overwrites any pending count; all others count down to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 1; r < REG_COUNT; r++) cnt[r] <= '0;
    end else if (!freeze) begin
      for (int r = 1; r < REG_COUNT; r++) begin
        if (issue_fire && (issue_dest == REG_ADDR_W'(r)))
          cnt[r] <= issue_is_load ? LOAD_TOT_C : ALU_TOT_C;
        else if (cnt[r] != '0)
          cnt[r] <= cnt[r] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= FETCH;
      prev_fetch <= 1'b0;
    end else begin
      prev_fetch <= (state == FETCH);
      if (!freeze) begin
        case (state)
          FETCH:   if (mem_req) state <= DATA;
          DATA:    state <= REFETCH;
          REFETCH: state <= FETCH;
          default: state <= FETCH;
        endcase
      end
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (reset)                       stall_cnt <= '0;
    else if (!freeze && hazard_stall) stall_cnt <= sat_inc32(stall_cnt);
  end

  assign stall_cycles = stall_cnt;
`else
  assign stall_cycles = sat_inc32(32'hFFFF_FFFF) & 32'd0;
`endif

endmodule

// File: tb/tb_pipe_scoreboard_hazard_unit.sv
// Directed bench for pipe_scoreboard_hazard_unit: expected outputs are queued per step and popped for checking.
module tb_pipe_scoreboard_hazard_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        waitrequest;
  logic        issue_valid;
  logic [4:0]  issue_rs, issue_rt, issue_dest;
  logic        issue_rs_used, issue_rt_used, issue_rs_early, issue_rt_early;
  logic        issue_dest_we, issue_is_load, mem_req;
  logic        pc_write, if_id_write, id_ex_bubble, fetch_mem_sel, if_id_valid, hazard_stall;
  logic [31:0] stall_cycles;

  int checks = 0;
  int errors = 0;
  int exp_stalls = 0;

  typedef struct packed {
    logic pc; logic bub; logic fs; logic ifv; logic hz;
  } exp_t;

  typedef struct packed {
    logic v; logic [4:0] rs; logic rsu; logic rse; logic [4:0] rt; logic rtu; logic rte;
    logic [4:0] dst; logic we; logic ld;
  } stim_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  pipe_scoreboard_hazard_unit dut (
    .clk(clk), .reset(reset), .waitrequest(waitrequest),
    .issue_valid(issue_valid), .issue_rs(issue_rs), .issue_rt(issue_rt),
    .issue_rs_used(issue_rs_used), .issue_rt_used(issue_rt_used),
    .issue_rs_early(issue_rs_early), .issue_rt_early(issue_rt_early),
    .issue_dest(issue_dest), .issue_dest_we(issue_dest_we), .issue_is_load(issue_is_load),
    .mem_req(mem_req), .pc_write(pc_write), .if_id_write(if_id_write),
    .id_ex_bubble(id_ex_bubble), .fetch_mem_sel(fetch_mem_sel), .if_id_valid(if_id_valid),
    .hazard_stall(hazard_stall), .stall_cycles(stall_cycles)
  );

  function automatic exp_t E(input logic pc, bub, fs, ifv, hz);
    exp_t e;
    e.pc = pc; e.bub = bub; e.fs = fs; e.ifv = ifv; e.hz = hz;
    return e;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic stim_t prod(input logic [4:0] dst, input logic ld);
    stim_t s;
    s = '0;
    s.v = 1'b1; s.dst = dst; s.we = 1'b1; s.ld = ld;
    return s;
  endfunction

  function automatic stim_t cons(input logic [4:0] rs, input logic rse,
                                 input logic [4:0] rt, input logic rtu, input logic rte,
                                 input logic [4:0] dst, input logic we);
    stim_t s;
    s = '0;
    s.v = 1'b1; s.rs = rs; s.rsu = 1'b1; s.rse = rse;
    s.rt = rt; s.rtu = rtu; s.rte = rte; s.dst = dst; s.we = we;
    return s;
  endfunction

  function automatic int exp_stat();
`ifdef HAZARD_STATS_EN
    return exp_stalls;
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string tag, input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want)
      else begin
        errors++;
        $error("FAIL %s %s got %0h want %0h", tag, name, got, want);
      end
  endtask

  // Called at a negedge: drive, queue expectation, check mid-phase, advance to next negedge.
  task automatic step(input string tag, input stim_t s, input logic mr, input logic wr, input exp_t e);
    exp_t x;
    issue_valid = s.v; issue_rs = s.rs; issue_rs_used = s.rsu; issue_rs_early = s.rse;
    issue_rt = s.rt; issue_rt_used = s.rtu; issue_rt_early = s.rte;
    issue_dest = s.dst; issue_dest_we = s.we; issue_is_load = s.ld;
    mem_req = mr; waitrequest = wr;
    exp_q.push_back(e);
    if (e.hz && !wr) exp_stalls++;
    #2;
    x = exp_q.pop_front();
    chk(tag, "pc_write", 32'(pc_write), 32'(x.pc));
    chk(tag, "if_id_write", 32'(if_id_write), 32'(x.pc));
    chk(tag, "id_ex_bubble", 32'(id_ex_bubble), 32'(x.bub));
    chk(tag, "fetch_mem_sel", 32'(fetch_mem_sel), 32'(x.fs));
    chk(tag, "if_id_valid", 32'(if_id_valid), 32'(x.ifv));
    chk(tag, "hazard_stall", 32'(hazard_stall), 32'(x.hz));
    @(negedge clk);
  endtask

  task automatic apply_reset(input int cycles);
    reset = 1'b1;
    issue_valid = 0; issue_rs = 0; issue_rt = 0; issue_rs_used = 0; issue_rt_used = 0;
    issue_rs_early = 0; issue_rt_early = 0; issue_dest = 0; issue_dest_we = 0;
    issue_is_load = 0; mem_req = 0; waitrequest = 0;
    repeat (cycles) @(negedge clk);
    reset = 1'b0;
    exp_stalls = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t N, H;
    stim_t p;
    N = E(1, 0, 1, 1, 0);
    H = E(0, 1, 1, 1, 1);

    apply_reset(2);
    step("rst0", idle(), 0, 0, E(1, 0, 1, 0, 0));
    chk("rst0", "stall_cycles", stall_cycles, 32'(exp_stat()));
    step("rst1", idle(), 0, 0, N);

    // load-use: one bubble
    step("lw5", prod(5, 1), 0, 0, N);
    step("addu_use5", cons(5, 0, 7, 1, 0, 6, 1), 0, 0, H);
    step("addu_use5_go", cons(5, 0, 7, 1, 0, 6, 1), 0, 0, N);
    step("idle_a", idle(), 0, 0, N);

    // ALU then branch: one bubble; load then branch: two
    step("addu3", prod(3, 0), 0, 0, N);
    step("beq3_a0", cons(3, 1, 0, 1, 1, 0, 0), 0, 0, H);
    step("beq3_a1", cons(3, 1, 0, 1, 1, 0, 0), 0, 0, N);
    step("lw3", prod(3, 1), 0, 0, N);
    step("beq3_l0", cons(3, 1, 0, 1, 1, 0, 0), 0, 0, H);
    step("beq3_l1", cons(3, 1, 0, 1, 1, 0, 0), 0, 0, H);
    step("beq3_l2", cons(3, 1, 0, 1, 1, 0, 0), 0, 0, N);

    // ALU then ALU: none; load-use through rt
    step("addu8", prod(8, 0), 0, 0, N);
    step("addu_use8", cons(8, 0, 0, 0, 0, 9, 1), 0, 0, N);
    step("lw10", prod(10, 1), 0, 0, N);
    step("rt_use10", cons(1, 0, 10, 1, 0, 11, 1), 0, 0, H);
    step("rt_use10_go", cons(1, 0, 10, 1, 0, 11, 1), 0, 0, N);
    chk("after_pairs", "stall_cycles", stall_cycles, 32'(exp_stat()));

    // $0 never tracked
    step("lw0", prod(0, 1), 0, 0, N);
    step("rd0", cons(0, 1, 0, 1, 1, 0, 0), 0, 0, N);

    // WAW reload: cnt[4] becomes ALU_LAT+EARLY_EXTRA=1 after addu $4
    step("lw4", prod(4, 1), 0, 0, N);
    step("addu4_a", cons(4, 0, 0, 0, 0, 4, 1), 0, 0, H);
    step("addu4_b", cons(4, 0, 0, 0, 0, 4, 1), 0, 0, N);
    step("beq4_a", cons(4, 1, 0, 0, 0, 0, 0), 0, 0, H);
    step("beq4_b", cons(4, 1, 0, 0, 0, 0, 0), 0, 0, N);

    // data access with 3 waitrequest cycles; counters hold while frozen
    step("lw5m", prod(5, 1), 0, 0, N);
    step("memreq", idle(), 1, 0, E(0, 0, 1, 1, 0));
    p = cons(5, 1, 0, 0, 0, 0, 0);
    step("data_w0", p, 1, 1, E(0, 0, 0, 0, 1));
    step("data_w1", p, 1, 1, E(0, 0, 0, 0, 1));
    step("data_w2", p, 1, 1, E(0, 0, 0, 0, 1));
    step("data_go", p, 0, 0, E(0, 1, 0, 0, 1));
    step("refetch", p, 0, 0, E(0, 0, 1, 0, 0));
    step("fetch0", idle(), 0, 0, E(1, 0, 1, 0, 0));
    step("fetch1", idle(), 0, 0, N);
    chk("after_data", "stall_cycles", stall_cycles, 32'(exp_stat()));

    // hazard and mem_req together
    step("lw11", prod(11, 1), 0, 0, N);
    step("hz_memreq", cons(11, 0, 0, 0, 0, 12, 1), 1, 0, E(0, 1, 1, 1, 1));
    step("hm_data", idle(), 0, 0, E(0, 0, 0, 0, 0));
    step("hm_refetch", idle(), 0, 0, E(0, 0, 1, 0, 0));
    step("hm_fetch0", idle(), 0, 0, E(1, 0, 1, 0, 0));
    step("hm_fetch1", idle(), 0, 0, N);

    // freeze in FETCH blocks the issue
    step("lw12_frozen", prod(12, 1), 0, 1, E(0, 0, 1, 0, 0));
    step("beq12", cons(12, 1, 0, 0, 0, 0, 0), 0, 0, N);
    chk("after_freeze", "stall_cycles", stall_cycles, 32'(exp_stat()));

    // reset mid-DATA discards pending counts
    step("lw13", prod(13, 1), 0, 0, N);
    step("memreq13", idle(), 1, 0, E(0, 0, 1, 1, 0));
    step("data13", idle(), 0, 1, E(0, 0, 0, 0, 0));
    apply_reset(1);
    step("post_rst_beq13", cons(13, 1, 0, 0, 0, 0, 0), 0, 0, E(1, 0, 1, 0, 0));
    chk("post_rst", "stall_cycles", stall_cycles, 32'(exp_stat()));
    step("post_rst_1", idle(), 0, 0, N);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
